// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ cache clients, with a
// burst lock per grant and abort of a grant on a persistent RAM ERROR.
module ram_port_arbiter #(
    parameter int NREQ      = 4,
    parameter int BLK_WORDS = 2,
    parameter int ERR_LIMIT = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         req_ren,
    input  logic [NREQ-1:0]         req_wen,
    input  logic [NREQ-1:0]         req_burst,
    input  logic [NREQ*32-1:0]      req_addr,
    input  logic [NREQ*32-1:0]      req_store,
    output logic [NREQ-1:0]         req_wait,
    output logic [31:0]             req_load,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    err_abort,
    output logic                    ramREN,
    output logic                    ramWEN,
    output logic [31:0]             ramaddr,
    output logic [31:0]             ramstore,
    input  logic [31:0]             ramload,
    input  logic [1:0]              ramstate
);
    localparam int IDW = $clog2(NREQ);
    localparam int BW  = $clog2(BLK_WORDS + 1);
    localparam int EW  = (ERR_LIMIT > 1) ? $clog2(ERR_LIMIT) : 1;
    localparam logic [BW-1:0] BEAT_MAX  = BW'(BLK_WORDS);
    localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_LIMIT - 1);
    localparam logic [1:0]    RS_ACCESS = 2'd2;
    localparam logic [1:0]    RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t          state_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  grant_q;
    logic [BW-1:0]   beat_q;
    logic [BW-1:0]   beat_d;
    logic [EW-1:0]   errcnt_q;
    logic [EW-1:0]   errcnt_d;
    logic [IDW-1:0]  winner_s;
    logic [IDW-1:0]  scan_s;
    logic            found_s;
    logic [NREQ-1:0] act_s;
    logic            g_ren_s;
    logic            g_wen_s;
    logic            g_burst_s;
    logic            idle_req_s;
    logic            access_s;
    logic            error_s;
    logic            abort_s;
    logic            release_s;

    assign act_s      = req_ren | req_wen;
    assign g_ren_s    = req_ren[grant_q];
    assign g_wen_s    = req_wen[grant_q];
    assign g_burst_s  = req_burst[grant_q];
    assign idle_req_s = !g_ren_s && !g_wen_s;
    assign access_s   = (state_q == ST_GRANT) && (ramstate == RS_ACCESS);
    assign error_s    = (state_q == ST_GRANT) && (ramstate == RS_ERROR);
    assign abort_s    = error_s && (errcnt_q == ERR_LAST);
    assign req_load   = ramload;
    assign grant_id   = grant_q;
    assign busy       = (state_q != ST_IDLE);
    assign err_abort  = abort_s;

    // Round-robin scan: first active client starting at ptr_q.
    always_comb begin
        winner_s = ptr_q;
        found_s  = 1'b0;
        scan_s   = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            scan_s = ptr_q + IDW'(k);
            if (!found_s && act_s[scan_s]) begin
                found_s  = 1'b1;
                winner_s = scan_s;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Beat/error counters and the grant-release decision.
    always_comb begin
        if (access_s && (beat_q != BEAT_MAX)) begin
            beat_d = beat_q + BW'(1);
        end else begin
            beat_d = beat_q;
        end
        if (error_s) begin
            errcnt_d = errcnt_q + EW'(1);
        end else if (state_q == ST_GRANT) begin
            errcnt_d = '0;
        end else begin
            errcnt_d = errcnt_q;
        end
        // A burst owner keeps the port until the full block has moved.
        if (abort_s) begin
            release_s = 1'b1;
        end else if (g_burst_s) begin
            release_s = idle_req_s && (beat_q == BEAT_MAX);
        end else begin
            release_s = idle_req_s || access_s;
        end
    end

    // RAM-side and client-side drive, decoded from the registered grant state.
    always_comb begin
        req_wait = '1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (state_q == ST_GRANT) begin
            ramaddr           = req_addr[{grant_q, 5'd0} +: 32];
            ramstore          = req_store[{grant_q, 5'd0} +: 32];
            ramWEN            = g_wen_s;
            ramREN            = g_ren_s && !g_wen_s;
            req_wait[grant_q] = (ramstate != RS_ACCESS);
        end else begin
            req_wait = '1;
        end
    end

    // Arbitration FSM.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            beat_q   <= '0;
            errcnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (found_s) begin
                        state_q  <= ST_GRANT;
                        grant_q  <= winner_s;
                        beat_q   <= '0;
                        errcnt_q <= '0;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    beat_q   <= beat_d;
                    errcnt_q <= errcnt_d;
                    if (release_s) begin
                        state_q <= ST_RELEASE;
                    end else begin
                        state_q <= ST_GRANT;
                    end
                end
                ST_RELEASE: begin
                    ptr_q   <= grant_q + IDW'(1);
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a transaction-level model predicts each
// cycle's outputs into a queue, and a negedge monitor pops and compares.
module tb_ram_port_arbiter;
    localparam int NREQ      = 4;
    localparam int BLK_WORDS = 2;
    localparam int ERR_LIMIT = 8;
    localparam logic [1:0] RS_FREE = 2'd0;
    localparam logic [1:0] RS_BUSY = 2'd1;
    localparam logic [1:0] RS_ACC  = 2'd2;
    localparam logic [1:0] RS_ERR  = 2'd3;

    logic         CLK = 1'b0;
    logic         RST;
    logic [3:0]   req_ren, req_wen, req_burst;
    logic [127:0] req_addr, req_store;
    logic [3:0]   req_wait;
    logic [31:0]  req_load;
    logic [1:0]   grant_id;
    logic         busy, err_abort, ramREN, ramWEN;
    logic [31:0]  ramaddr, ramstore, ramload;
    logic [1:0]   ramstate;

    always #5 CLK = ~CLK;

    ram_port_arbiter #(.NREQ(NREQ), .BLK_WORDS(BLK_WORDS), .ERR_LIMIT(ERR_LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .req_ren(req_ren), .req_wen(req_wen), .req_burst(req_burst),
        .req_addr(req_addr), .req_store(req_store),
        .req_wait(req_wait), .req_load(req_load),
        .grant_id(grant_id), .busy(busy), .err_abort(err_abort),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    typedef struct packed {
        logic [3:0]  wait_v;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] load;
        logic        busy;
        logic [1:0]  gid;
        logic        abort;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    // model: current owner (-1 = none), turnaround flag, next-start pointer
    int   m_owner, m_rr, m_beats, m_errs;
    bit   m_turn;

    int   glog[$];
    int   exp_log[5];
    int   wr_cnt, ab_cnt;
    logic prev_busy = 1'b0;

    logic [3:0] r_ren, r_wen, r_bs;
    logic [1:0] r_rs;
    int         storm = 0;
    int         pick;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_log(input string nm, input int n);
        chk({nm, "_len"}, 32'(glog.size()), 32'(n));
        for (int i = 0; i < n && i < glog.size(); i++)
            chk($sformatf("%s_g%0d", nm, i), 32'(glog[i]), 32'(exp_log[i]));
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_turn  = 1'b0;
        m_rr    = 0;
        m_beats = 0;
        m_errs  = 0;
    endtask

    // Predict this cycle's outputs from current inputs, then advance one edge.
    task automatic model_step();
        exp_t e;
        int   o;
        bit   acc, err, quiet, done;
        o        = m_owner;
        e.wait_v = 4'hF;
        e.ren    = 1'b0;
        e.wen    = 1'b0;
        e.addr   = 32'h0;
        e.store  = 32'h0;
        e.load   = ramload;
        e.busy   = (o >= 0);
        e.gid    = (o >= 0) ? 2'(o) : 2'b00;
        e.abort  = 1'b0;
        acc      = (ramstate == RS_ACC);
        err      = (ramstate == RS_ERR);
        if (o >= 0 && !m_turn) begin
            e.addr      = req_addr[32*o +: 32];
            e.store     = req_store[32*o +: 32];
            e.wen       = req_wen[o];
            e.ren       = req_ren[o] && !req_wen[o];
            e.wait_v[o] = !acc;
            e.abort     = err && (m_errs == ERR_LIMIT - 1);
        end
        exp_q.push_back(e);

        if (RST) begin
            model_reset();
        end else if (o >= 0 && !m_turn) begin
            quiet = !req_ren[o] && !req_wen[o];
            if (err && m_errs == ERR_LIMIT - 1) done = 1'b1;
            else if (req_burst[o])              done = quiet && (m_beats == BLK_WORDS);
            else                                done = quiet || acc;
            if (acc && m_beats < BLK_WORDS) m_beats++;
            m_errs = err ? m_errs + 1 : 0;
            if (done) m_turn = 1'b1;
        end else if (m_turn) begin
            m_rr    = (o + 1) % NREQ;
            m_owner = -1;
            m_turn  = 1'b0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_rr + k) % NREQ;
                if (m_owner < 0 && (req_ren[c] || req_wen[c])) begin
                    m_owner = c;
                    m_beats = 0;
                    m_errs  = 0;
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] rn, input logic [3:0] wn,
                         input logic [3:0] bs, input logic [1:0] rs);
        @(posedge CLK);
        #1;
        RST       = r;
        req_ren   = rn;
        req_wen   = wn;
        req_burst = bs;
        ramstate  = rs;
        req_addr  = {$urandom, $urandom, $urandom, $urandom};
        req_store = {$urandom, $urandom, $urandom, $urandom};
        ramload   = $urandom;
        model_step();
    endtask

    task automatic settle();
        @(negedge CLK);
        #1;
    endtask

    task automatic start_scn();
        drive(1'b1, 4'h0, 4'h0, 4'h0, RS_FREE);
        settle();
        glog.delete();
        wr_cnt = 0;
        ab_cnt = 0;
    endtask

    // Monitor: pop one prediction per cycle and compare against the DUT.
    initial begin
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("req_wait", 32'(req_wait), 32'(mon_e.wait_v));
                chk("ramREN", 32'(ramREN), 32'(mon_e.ren));
                chk("ramWEN", 32'(ramWEN), 32'(mon_e.wen));
                chk("ramaddr", ramaddr, mon_e.addr);
                chk("ramstore", ramstore, mon_e.store);
                chk("req_load", req_load, mon_e.load);
                chk("busy", 32'(busy), 32'(mon_e.busy));
                chk("err_abort", 32'(err_abort), 32'(mon_e.abort));
                if (mon_e.busy) chk("grant_id", 32'(grant_id), 32'(mon_e.gid));
                if (busy && !prev_busy) glog.push_back(int'(grant_id));
                if (ramWEN && ramstate == RS_ACC) wr_cnt++;
                if (err_abort) ab_cnt++;
                prev_busy = busy;
            end
        end
    end

    initial begin
        RST = 1'b1; req_ren = '0; req_wen = '0; req_burst = '0;
        req_addr = '0; req_store = '0; ramload = '0; ramstate = RS_FREE;
        model_reset();
        repeat (2) @(posedge CLK);

        // 1: single client, grant latency, wait mask, pointer moves past it
        start_scn();
        drive(1'b0, 4'b0100, 4'h0, 4'h0, RS_FREE);
        drive(1'b0, 4'b0100, 4'h0, 4'h0, RS_BUSY);
        drive(1'b0, 4'b0100, 4'h0, 4'h0, RS_ACC);
        settle();
        chk("t1_wait", 32'(req_wait), 32'hB);
        chk("t1_gid", 32'(grant_id), 32'd2);
        drive(1'b0, 4'b1100, 4'h0, 4'h0, RS_FREE);
        drive(1'b0, 4'b1100, 4'h0, 4'h0, RS_FREE);
        drive(1'b0, 4'b1100, 4'h0, 4'h0, RS_ACC);
        drive(1'b0, 4'h0, 4'h0, 4'h0, RS_FREE);
        drive(1'b0, 4'h0, 4'h0, 4'h0, RS_FREE);
        settle();
        exp_log = '{2, 3, 0, 0, 0};
        chk_log("t1", 2);

        // 2: all clients requesting, rotation order
        start_scn();
        repeat (15) drive(1'b0, 4'hF, 4'h0, 4'h0, RS_ACC);
        drive(1'b0, 4'h0, 4'h0, 4'h0, RS_FREE);
        drive(1'b0, 4'h0, 4'h0, 4'h0, RS_FREE);
        settle();
        exp_log = '{0, 1, 2, 3, 0};
        chk_log("t2", 5);

        // 3: burst write lock, other client waits
        start_scn();
        drive(1'b0, 4'b1000, 4'b0010, 4'b0010, RS_FREE);
        drive(1'b0, 4'b1000, 4'b0010, 4'b0010, RS_BUSY);
        drive(1'b0, 4'b1000, 4'b0010, 4'b0010, RS_ACC);
        drive(1'b0, 4'b1000, 4'b0010, 4'b0010, RS_BUSY);
        drive(1'b0, 4'b1000, 4'b0010, 4'b0010, RS_ACC);
        drive(1'b0, 4'b1000, 4'b0000, 4'b0010, RS_FREE);
        drive(1'b0, 4'b1000, 4'h0, 4'h0, RS_FREE);
        drive(1'b0, 4'b1000, 4'h0, 4'h0, RS_FREE);
        drive(1'b0, 4'b1000, 4'h0, 4'h0, RS_ACC);
        drive(1'b0, 4'h0, 4'h0, 4'h0, RS_FREE);
        drive(1'b0, 4'h0, 4'h0, 4'h0, RS_FREE);
        settle();
        chk("t3_writes", 32'(wr_cnt), 32'd2);
        exp_log = '{1, 3, 0, 0, 0};
        chk_log("t3", 2);

        // 4: ERROR abort on the ERR_LIMIT-th consecutive ERROR cycle
        start_scn();
        drive(1'b0, 4'b0011, 4'h0, 4'h0, RS_FREE);
        repeat (ERR_LIMIT - 1) drive(1'b0, 4'b0011, 4'h0, 4'h0, RS_ERR);
        settle();
        chk("t4_no_early_abort", 32'(ab_cnt), 32'd0);
        drive(1'b0, 4'b0011, 4'h0, 4'h0, RS_ERR);
        settle();
        chk("t4_abort", 32'(ab_cnt), 32'd1);
        chk("t4_wait0", 32'(req_wait[0]), 32'd1);
        drive(1'b0, 4'b0011, 4'h0, 4'h0, RS_FREE);
        drive(1'b0, 4'b0011, 4'h0, 4'h0, RS_FREE);
        drive(1'b0, 4'b0011, 4'h0, 4'h0, RS_ACC);
        drive(1'b0, 4'h0, 4'h0, 4'h0, RS_FREE);
        settle();
        exp_log = '{0, 1, 0, 0, 0};
        chk_log("t4", 2);

        // 5: ren+wen writes; ERROR run one short of the limit then ACCESS
        start_scn();
        drive(1'b0, 4'b0001, 4'b0001, 4'h0, RS_FREE);
        repeat (ERR_LIMIT - 1) drive(1'b0, 4'b0001, 4'b0001, 4'h0, RS_ERR);
        drive(1'b0, 4'b0001, 4'b0001, 4'h0, RS_ACC);
        drive(1'b0, 4'h0, 4'h0, 4'h0, RS_FREE);
        drive(1'b0, 4'h0, 4'h0, 4'h0, RS_FREE);
        settle();
        chk("t5_abort", 32'(ab_cnt), 32'd0);
        chk("t5_writes", 32'(wr_cnt), 32'd1);

        // 6: reset in the middle of a burst
        start_scn();
        drive(1'b0, 4'b0010, 4'h0, 4'h0, RS_FREE);
        drive(1'b0, 4'b0010, 4'h0, 4'h0, RS_ACC);
        drive(1'b0, 4'b0100, 4'h0, 4'b0100, RS_FREE);
        drive(1'b0, 4'b0100, 4'h0, 4'b0100, RS_FREE);
        drive(1'b0, 4'b0100, 4'h0, 4'b0100, RS_ACC);
        drive(1'b1, 4'b0100, 4'h0, 4'b0100, RS_BUSY);
        drive(1'b0, 4'hF, 4'h0, 4'h0, RS_FREE);
        settle();
        chk("t6_wait", 32'(req_wait), 32'hF);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ren", 32'(ramREN), 32'd0);
        chk("t6_gid", 32'(grant_id), 32'd0);
        drive(1'b0, 4'hF, 4'h0, 4'h0, RS_ACC);
        drive(1'b0, 4'h0, 4'h0, 4'h0, RS_FREE);
        drive(1'b0, 4'h0, 4'h0, 4'h0, RS_FREE);
        settle();
        exp_log = '{1, 2, 0, 0, 0};
        chk_log("t6", 3);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            r_ren = 4'($urandom) & 4'($urandom);
            r_wen = 4'($urandom) & 4'($urandom) & 4'($urandom);
            r_bs  = 4'($urandom);
            if (storm == 0 && $urandom_range(0, 199) == 0) storm = ERR_LIMIT + 1;
            if (storm > 0) begin
                r_rs = RS_ERR;
                storm--;
            end else begin
                pick = int'($urandom_range(0, 9));
                if (pick < 4)      r_rs = RS_ACC;
                else if (pick < 6) r_rs = RS_BUSY;
                else if (pick < 8) r_rs = RS_FREE;
                else               r_rs = RS_ERR;
            end
            drive(($urandom_range(0, 299) == 0), r_ren, r_wen, r_bs, r_rs);
        end
        drive(1'b0, 4'h0, 4'h0, 4'h0, RS_FREE);
        settle();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
